// File: rtl/nav_datapath.sv
// nav_datapath: maze-walker location datapath with bounds checking, backtrack stack,
// valid/ready command port, goal detection and saturating step counter.
module nav_datapath #(
    parameter int CW = 4,
    parameter int DEPTH = 16,
    parameter logic [CW-1:0] GOAL_X = '1,
    parameter logic [CW-1:0] GOAL_Y = '1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [1:0]                   dir,
    output logic                         done,
    output logic [1:0]                   status,
    output logic [CW-1:0]                cur_x,
    output logic [CW-1:0]                cur_y,
    output logic [CW-1:0]                nxt_x,
    output logic [CW-1:0]                nxt_y,
    output logic                         edge_hit,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         at_goal,
    output logic [15:0]                  step_cnt
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [1:0] OP_MOVE = 2'b00, OP_PUSH = 2'b01, OP_BACK = 2'b10;
    localparam logic [1:0] ST_OK = 2'b00, ST_BOUND = 2'b01, ST_FULL = 2'b10, ST_EMPTY = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WB} state_t;
    state_t state, state_n;

    logic [2*CW-1:0] mem [DEPTH];
    logic [2*CW-1:0] rd_q;
    logic [CW-1:0]   coord, stepped;
    logic [AW-1:0]   wa, ra;
    logic            axis, plus, done_n, mv, push, pop, clr;
    logic [1:0]      status_n;

    // axis: 1 selects x, 0 selects y; dir[0] chooses +1 over -1
    assign axis     = ^dir;
    assign plus     = dir[0];
    assign coord    = axis ? cur_x : cur_y;
    assign edge_hit = plus ? &coord : ~|coord;
    assign stepped  = plus ? coord + 1'b1 : coord - 1'b1;
    assign nxt_x    = axis ? stepped : cur_x;
    assign nxt_y    = axis ? cur_y : stepped;

    assign empty     = depth == '0;
    assign full      = depth == DW'(DEPTH);
    assign at_goal   = (cur_x == GOAL_X) && (cur_y == GOAL_Y);
    assign cmd_ready = (state == IDLE) && !rst;
    assign wa        = AW'(depth);
    assign ra        = AW'(depth - 1'b1);

    always_comb begin
        state_n  = state;
        done_n   = 1'b0;
        status_n = status;
        mv       = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                done_n = 1'b1;
                case (cmd_op)
                    OP_MOVE: begin
                        status_n = edge_hit ? ST_BOUND : ST_OK;
                        mv       = !edge_hit;
                    end
                    OP_PUSH: begin
                        status_n = full ? ST_FULL : edge_hit ? ST_BOUND : ST_OK;
                        push     = !full && !edge_hit;
                        mv       = push;
                    end
                    OP_BACK: begin
                        status_n = empty ? ST_EMPTY : status;
                        done_n   = empty;
                        state_n  = empty ? IDLE : RD;
                    end
                    default: begin
                        status_n = ST_OK;
                        clr      = 1'b1;
                    end
                endcase
            end
            RD: state_n = WB;
            WB: begin
                state_n  = IDLE;
                pop      = 1'b1;
                done_n   = 1'b1;
                status_n = ST_OK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            status   <= ST_OK;
            cur_x    <= '0;
            cur_y    <= '0;
            depth    <= '0;
            step_cnt <= '0;
        end else begin
            state  <= state_n;
            done   <= done_n;
            status <= status_n;
            if (clr) begin
                cur_x    <= '0;
                cur_y    <= '0;
                depth    <= '0;
                step_cnt <= '0;
            end else begin
                if (mv) {cur_x, cur_y} <= {nxt_x, nxt_y};
                if (pop) {cur_x, cur_y} <= rd_q;
                if (push) depth <= depth + 1'b1;
                else if (pop) depth <= depth - 1'b1;
                if ((mv || pop) && !(&step_cnt)) step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // stack storage has no reset; only entries below depth are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wa] <= {cur_x, cur_y};
        if (state == RD) rd_q <= mem[ra];
    end
endmodule

// File: tb/tb_nav_datapath.sv
// tb_nav_datapath: scoreboard bench for nav_datapath (CW=4, DEPTH=4); a model predicts
// each command's response at issue time and the monitor checks it when done pulses.
module tb_nav_datapath;
    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00, dir = 2'b00;
    logic       cmd_ready, done, edge_hit, empty, full, at_goal;
    logic [1:0] status;
    logic [3:0] cur_x, cur_y, nxt_x, nxt_y;
    logic [2:0] depth;
    logic [15:0] step_cnt;

    typedef struct packed {
        logic [1:0]  st;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [2:0]  dep;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    logic [7:0] stk[$];
    int mx = 0, my = 0, mcnt = 0;
    int vectors = 0, miscompares = 0;

    nav_datapath #(.CW(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .dir(dir), .done(done), .status(status),
        .cur_x(cur_x), .cur_y(cur_y), .nxt_x(nxt_x), .nxt_y(nxt_y),
        .edge_hit(edge_hit), .depth(depth), .empty(empty), .full(full),
        .at_goal(at_goal), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && done) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got done with status %0d, none expected", status);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({status, cur_x, cur_y, depth, step_cnt} !== e) begin
                    miscompares++;
                    $display("FAIL response: got st=%0d cur=(%0d,%0d) dep=%0d cnt=%0d, want st=%0d cur=(%0d,%0d) dep=%0d cnt=%0d",
                             status, cur_x, cur_y, depth, step_cnt, e.st, e.x, e.y, e.dep, e.cnt);
                end
            end
        end
    end

    task automatic model(input logic [1:0] op, input logic [1:0] d);
        int nx, ny;
        bit oob;
        logic [1:0] st;
        logic [7:0] ent;
        nx = mx + (d == 2'b01 ? 1 : d == 2'b10 ? -1 : 0);
        ny = my + (d == 2'b11 ? 1 : d == 2'b00 ? -1 : 0);
        oob = nx < 0 || nx > 15 || ny < 0 || ny > 15;
        st = 2'b00;
        case (op)
            2'b00: if (oob) st = 2'b01; else begin mx = nx; my = ny; mcnt++; end
            2'b01: if (stk.size() == 4) st = 2'b10;
                   else if (oob) st = 2'b01;
                   else begin stk.push_back({4'(mx), 4'(my)}); mx = nx; my = ny; mcnt++; end
            2'b10: if (stk.size() == 0) st = 2'b11;
                   else begin ent = stk.pop_back(); mx = int'(ent[7:4]); my = int'(ent[3:0]); mcnt++; end
            default: begin mx = 0; my = 0; mcnt = 0; stk.delete(); end
        endcase
        if (mcnt > 65535) mcnt = 65535;
        q.push_back({st, 4'(mx), 4'(my), 3'(stk.size()), 16'(mcnt)});
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: cmd_ready=%0d after %0d cycles, want 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        dir = d;
        model(op, d);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({cur_x, cur_y, depth, empty, full, step_cnt, done, status, cmd_ready} !== {4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 16'd0, 1'b0, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: cur=(%0d,%0d) dep=%0d e=%0d f=%0d cnt=%0d done=%0d st=%0d rdy=%0d",
                     cur_x, cur_y, depth, empty, full, step_cnt, done, status, cmd_ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || at_goal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: rdy=%0d goal=%0d, want 1 0", cmd_ready, at_goal);
        end
    endtask

    task automatic test_move();
        repeat (3) issue(2'b00, 2'b01);
        drain();
        vectors++;
        if ({cur_x, cur_y, step_cnt} !== {4'd3, 4'd0, 16'd3}) begin
            miscompares++;
            $display("FAIL move_x3: cur=(%0d,%0d) cnt=%0d, want (3,0) 3", cur_x, cur_y, step_cnt);
        end
    endtask

    task automatic test_bounds();
        issue(2'b11, 2'b00);
        @(negedge clk);
        dir = 2'b10;
        #1;
        vectors++;
        if (edge_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_left: edge_hit=%0d, want 1", edge_hit);
        end
        issue(2'b00, 2'b10);
        issue(2'b00, 2'b00);
        repeat (15) issue(2'b00, 2'b01);
        @(negedge clk);
        dir = 2'b01;
        #1;
        vectors++;
        if (edge_hit !== 1'b1 || nxt_x !== 4'd0 || nxt_y !== 4'd0) begin
            miscompares++;
            $display("FAIL edge_right: edge_hit=%0d nxt=(%0d,%0d), want 1 (0,0)", edge_hit, nxt_x, nxt_y);
        end
        issue(2'b00, 2'b01);
        drain();
    endtask

    task automatic test_stack();
        issue(2'b11, 2'b00);
        repeat (5) issue(2'b01, 2'b11);
        drain();
        vectors++;
        if ({cur_x, cur_y, depth, full} !== {4'd0, 4'd4, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL stack_full: cur=(%0d,%0d) dep=%0d full=%0d, want (0,4) 4 1", cur_x, cur_y, depth, full);
        end
        issue(2'b10, 2'b11);
        @(negedge clk);
        dir = 2'b01;
        cmd_op = 2'b00;
        vectors++;
        if (cmd_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL back_rd: rdy=%0d done=%0d, want 0 0", cmd_ready, done);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0 || depth !== 3'd4) begin
            miscompares++;
            $display("FAIL back_wb: rdy=%0d dep=%0d, want 0 4", cmd_ready, depth);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || done !== 1'b1 || {cur_x, cur_y, depth} !== {4'd0, 4'd3, 3'd3}) begin
            miscompares++;
            $display("FAIL back_done: rdy=%0d done=%0d cur=(%0d,%0d) dep=%0d, want 1 1 (0,3) 3",
                     cmd_ready, done, cur_x, cur_y, depth);
        end
        repeat (4) issue(2'b10, 2'b00);
        drain();
        vectors++;
        if ({cur_x, cur_y, empty} !== {4'd0, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL stack_empty: cur=(%0d,%0d) empty=%0d, want (0,0) 1", cur_x, cur_y, empty);
        end
        issue(2'b10, 2'b00);
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || status !== 2'b11 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL back_empty: done=%0d st=%0d rdy=%0d, want 1 3 1", done, status, cmd_ready);
        end
        drain();
    endtask

    task automatic test_abort();
        issue(2'b01, 2'b01);
        issue(2'b10, 2'b00);
        rst = 1'b1;
        q.delete();
        stk.delete();
        mx = 0;
        my = 0;
        mcnt = 0;
        #1;
        vectors++;
        if ({cur_x, cur_y, depth, done, cmd_ready} !== {4'd0, 4'd0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_reset: cur=(%0d,%0d) dep=%0d done=%0d rdy=%0d", cur_x, cur_y, depth, done, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || depth !== 3'd0) begin
                miscompares++;
                $display("FAIL abort_after: done=%0d rdy=%0d dep=%0d, want 0 1 0", done, cmd_ready, depth);
            end
        end
    endtask

    task automatic test_back_to_back();
        repeat (15) issue(2'b00, 2'b01);
        repeat (15) issue(2'b00, 2'b11);
        drain();
        vectors++;
        if (at_goal !== 1'b1 || step_cnt !== 16'd30) begin
            miscompares++;
            $display("FAIL goal: at_goal=%0d cnt=%0d, want 1 30", at_goal, step_cnt);
        end
        issue(2'b11, 2'b10);
        drain();
        vectors++;
        if ({cur_x, cur_y, step_cnt, at_goal} !== {4'd0, 4'd0, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clear: cur=(%0d,%0d) cnt=%0d goal=%0d, want (0,0) 0 0", cur_x, cur_y, step_cnt, at_goal);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_bounds();
        test_stack();
        test_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
